// File: rtl/seq_multiplier.sv
// Iterative N-bit shift-add multiplier with start/ready handshake and a one-cycle done pulse.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands using Booth radix-2 recoding.
module seq_multiplier #(
    parameter int N = 4
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   product,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N:0]      a_reg;
    logic [N-1:0]    q_reg;
    logic [N-1:0]    m_reg;
    logic [CW-1:0]   count;
    logic [N:0]      m_ext;
    logic [N:0]      sum;
    logic [N:0]      next_a;
    logic [N-1:0]    next_q;
`ifdef SEQ_MUL_SIGNED_EN
    logic            q1;
`endif

    // A carries one guard bit so the add never overflows before the shift.
    always_comb begin
        m_ext  = '0;
        sum    = a_reg;
        next_a = '0;
        next_q = '0;
`ifdef SEQ_MUL_SIGNED_EN
        m_ext = {m_reg[N-1], m_reg};
        case ({q_reg[0], q1})
            2'b10:   sum = a_reg - m_ext;
            2'b01:   sum = a_reg + m_ext;
            default: sum = a_reg;
        endcase
        next_a = {sum[N], sum[N:1]};
`else
        m_ext  = {1'b0, m_reg};
        sum    = a_reg + (q_reg[0] ? m_ext : '0);
        next_a = {1'b0, sum[N:1]};
`endif
        next_q = {sum[0], q_reg[N-1:1]};
    end

    assign product = {a_reg[N-1:0], q_reg};

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            count <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            q1    <= 1'b0;
`endif
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        count <= COUNT_INIT;
`ifdef SEQ_MUL_SIGNED_EN
                        q1    <= 1'b0;
`endif
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_reg <= next_a;
                    q_reg <= next_q;
`ifdef SEQ_MUL_SIGNED_EN
                    q1    <= q_reg[0];
`endif
                    count <= count - 1'b1;
                    // The step taken with count==0 is the last of N steps.
                    if (count == '0) begin
                        state <= DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=4 and N=8) against an arithmetic reference model.
// Honours SEQ_MUL_SIGNED_EN in the same way as the design.
module tb_seq_multiplier;

    logic        clock = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  multiplicand = '0;
    logic [3:0]  multiplier = '0;
    logic [7:0]  product;
    logic        ready, busy, done;

    logic        start8 = 1'b0;
    logic [7:0]  multiplicand8 = '0;
    logic [7:0]  multiplier8 = '0;
    logic [15:0] product8;
    logic        ready8, busy8, done8;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seq_multiplier #(.N(4)) dut (
        .clock(clock), .n_reset(n_reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product(product), .ready(ready), .busy(busy), .done(done)
    );

    seq_multiplier #(.N(8)) dut8 (
        .clock(clock), .n_reset(n_reset), .start(start8),
        .multiplicand(multiplicand8), .multiplier(multiplier8),
        .product(product8), .ready(ready8), .busy(busy8), .done(done8)
    );

    // Reference: plain integer multiplication of the operand values, truncated to 2n bits.
    function automatic logic [15:0] model(int n, logic [7:0] a, logic [7:0] b);
        longint x, y, r;
        x = longint'(a) & ((64'sd1 << n) - 1);
        y = longint'(b) & ((64'sd1 << n) - 1);
`ifdef SEQ_MUL_SIGNED_EN
        if (x >= (64'sd1 << (n - 1))) x = x - (64'sd1 << n);
        if (y >= (64'sd1 << (n - 1))) y = y - (64'sd1 << n);
`endif
        r = (x * y) & ((64'sd1 << (2 * n)) - 1);
        return 16'(r);
    endfunction

    task automatic check_output(string tag, logic [15:0] observed, logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(logic [3:0] a, logic [3:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
    endtask

    // Called at a negedge with start already raised; returns at the negedge of the first DONE cycle.
    task automatic wait_done(string tag, logic [7:0] expected, bit hold);
        int low;
        int early_done;
        @(negedge clock);
        if (!hold) start = 1'b0;
        low = 0;
        early_done = 0;
        while (ready !== 1'b1 && low < 20) begin
            if (done === 1'b1) early_done++;
            if (busy !== 1'b1) early_done += 100;
            if (hold) begin
                multiplicand = 4'($urandom);
                multiplier   = 4'($urandom);
            end
            low++;
            @(negedge clock);
        end
        check_output({tag, " latency"}, 16'(low), 16'd4);
        check_output({tag, " run flags"}, 16'(early_done), 16'd0);
        check_output({tag, " done"}, {15'd0, done}, 16'd1);
        check_output({tag, " busy"}, {15'd0, busy}, 16'd0);
        check_output({tag, " product"}, {8'd0, product}, {8'd0, expected});
    endtask

    task automatic check_hold(string tag, logic [7:0] expected);
        @(negedge clock);
        check_output({tag, " done dropped"}, {15'd0, done}, 16'd0);
        check_output({tag, " ready held"}, {15'd0, ready}, 16'd1);
        check_output({tag, " product held"}, {8'd0, product}, {8'd0, expected});
    endtask

    initial begin
        logic [3:0] ra, rb;
        int low8;
        int stray;

        $display("[TB] reset");
        #12;
        check_output("reset product", {8'd0, product}, 16'd0);
        check_output("reset ready", {15'd0, ready}, 16'd1);
        check_output("reset busy", {15'd0, busy}, 16'd0);
        check_output("reset done", {15'd0, done}, 16'd0);
        @(negedge clock);
        n_reset = 1'b1;
        @(negedge clock);

        $display("[TB] directed operands");
        apply_stimulus(4'd13, 4'd11);
        wait_done("13x11", model(4, 8'd13, 8'd11), 1'b0);
        check_hold("13x11", model(4, 8'd13, 8'd11));
`ifdef SEQ_MUL_SIGNED_EN
        check_output("13x11 const", {8'd0, product}, 16'h000F);
        apply_stimulus(4'hD, 4'd5);
        wait_done("-3x5", 8'hF1, 1'b0);
        apply_stimulus(4'h8, 4'h8);
        wait_done("-8x-8", 8'h40, 1'b0);
        apply_stimulus(4'd7, 4'hF);
        wait_done("7x-1", 8'hF9, 1'b0);
`else
        check_output("13x11 const", {8'd0, product}, 16'h008F);
        apply_stimulus(4'd15, 4'd15);
        wait_done("15x15", 8'hE1, 1'b0);
        apply_stimulus(4'd0, 4'd9);
        wait_done("0x9", 8'h00, 1'b0);
`endif

        $display("[TB] back-to-back");
        apply_stimulus(4'd3, 4'd5);
        wait_done("3x5", 8'h0F, 1'b0);
        apply_stimulus(4'd7, 4'd2);
        wait_done("7x2", 8'h0E, 1'b0);
        check_hold("7x2", 8'h0E);

        $display("[TB] start held with operands changing mid-run");
        apply_stimulus(4'd9, 4'd6);
        wait_done("held", model(4, 8'd9, 8'd6), 1'b1);
        ra = multiplicand;
        rb = multiplier;
        wait_done("resampled", model(4, {4'd0, ra}, {4'd0, rb}), 1'b0);

        $display("[TB] random operands");
        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            apply_stimulus(ra, rb);
            wait_done("random", model(4, {4'd0, ra}, {4'd0, rb}), 1'b0);
        end

        $display("[TB] reset during run");
        @(negedge clock);
        apply_stimulus(4'd13, 4'd11);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_reset = 1'b0;
        #1;
        check_output("abort product", {8'd0, product}, 16'd0);
        check_output("abort ready", {15'd0, ready}, 16'd1);
        check_output("abort busy", {15'd0, busy}, 16'd0);
        check_output("abort done", {15'd0, done}, 16'd0);
        @(negedge clock);
        n_reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || ready !== 1'b1 || product !== 8'd0) stray++;
        end
        check_output("abort stays idle", 16'(stray), 16'd0);

        $display("[TB] N=8");
        multiplicand8 = 8'd255;
        multiplier8   = 8'd255;
        start8        = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        low8 = 0;
        while (ready8 !== 1'b1 && low8 < 40) begin
            low8++;
            @(negedge clock);
        end
        check_output("n8 latency", 16'(low8), 16'd8);
        check_output("n8 done", {15'd0, done8}, 16'd1);
        check_output("n8 product", product8, model(8, 8'd255, 8'd255));
`ifndef SEQ_MUL_SIGNED_EN
        check_output("n8 const", product8, 16'hFE01);
`endif
        for (int i = 0; i < 4; i++) begin
            multiplicand8 = 8'($urandom);
            multiplier8   = 8'($urandom);
            start8        = 1'b1;
            @(negedge clock);
            start8 = 1'b0;
            low8 = 0;
            while (ready8 !== 1'b1 && low8 < 40) begin
                low8++;
                @(negedge clock);
            end
            check_output("n8 random latency", 16'(low8), 16'd8);
            check_output("n8 random product", product8, model(8, multiplicand8, multiplier8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
